cmt_queue: RTL and testbench

- Parametrised multi-lane commit unit for difftest.
- Accepts up to NCMT retired instructions per cycle from writeback and buffers them in a DEPTH-entry FIFO.
- Drains the FIFO in program order onto NCMT registered commit lanes that feed the difftest instr-commit and trap-event probes.
- Adds, compared with the previous single-lane unit: trap latching, cycle/instruction counters, a no-commit watchdog, and overflow/ordering error flags.

---
 rtl/cmt_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_cmt_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmt_queue.sv
`timescale 1ns/1ps
// Multi-lane difftest commit unit: buffers retired groups in a FIFO and drains them in
// program order onto registered commit lanes, with trap latching, counters and a watchdog.
module cmt_queue #(
    parameter int NCMT    = 2,
    parameter int DEPTH   = 8,
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCMT-1:0]      i_valid,
    input  logic [NCMT*XLEN-1:0] i_pc,
    input  logic [NCMT*32-1:0]   i_inst,
    input  logic [NCMT*5-1:0]    i_rd,
    input  logic [NCMT-1:0]      i_rd_wen,
    input  logic [NCMT*XLEN-1:0] i_rd_wdata,
    input  logic [NCMT-1:0]      i_skip,
    input  logic [XLEN-1:0]      i_a0,
    input  logic                 i_out_stall,
    output logic                 o_ready,
    output logic [NCMT-1:0]      o_cmt_valid,
    output logic [NCMT*XLEN-1:0] o_cmt_pc,
    output logic [NCMT*32-1:0]   o_cmt_inst,
    output logic [NCMT*8-1:0]    o_cmt_wdest,
    output logic [NCMT-1:0]      o_cmt_wen,
    output logic [NCMT*XLEN-1:0] o_cmt_wdata,
    output logic [NCMT-1:0]      o_cmt_skip,
    output logic                 o_trap,
    output logic [7:0]           o_trap_code,
    output logic [XLEN-1:0]      o_trap_pc,
    output logic [63:0]          o_cycle_cnt,
    output logic [63:0]          o_instr_cnt,
    output logic                 o_overflow,
    output logic                 o_order_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] TRAP_OP = 7'h6b;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_inst  [DEPTH];
    logic [4:0]      mem_rd    [DEPTH];
    logic            mem_wen   [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];
    logic            mem_skip  [DEPTH];
    logic [7:0]      mem_code  [DEPTH];

    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               trap_enq_q, trap_q, overflow_q, order_q;
    logic [7:0]         trap_code_q;
    logic [XLEN-1:0]    trap_pc_q, last_pc_q;
    logic [63:0]        cycle_q, instr_q;
    logic [WW-1:0]      wdog_q;
    logic [NCMT-1:0]    valid_q, wen_q, skip_q;
    logic [NCMT*XLEN-1:0] pc_q, wdata_q;
    logic [NCMT*32-1:0] inst_q;
    logic [NCMT*8-1:0]  wdest_q;

    logic [AW-1:0]      wr_idx [NCMT];
    logic [AW-1:0]      rd_idx [NCMT];
    logic [NCMT-1:0]    in_trap, ent_trap, take;
    logic [NCMT-1:0]    valid_d, wen_d, skip_d;
    logic [NCMT*XLEN-1:0] pc_d, wdata_d;
    logic [NCMT*32-1:0] inst_d;
    logic [NCMT*8-1:0]  wdest_d;
    logic [CW-1:0]      n_enq, n_deq;
    logic               enq_stop, deq_stop, grp_trap, deq_trap, gap;
    logic [7:0]         deq_code;
    logic [XLEN-1:0]    deq_pc, deq_last_pc;
    logic               unused_a0;

    assign unused_a0 = ^i_a0[XLEN-1:8];
    // A set bit above a clear bit means the valid lanes are not a prefix from lane 0.
    assign gap       = |(i_valid & (i_valid + NCMT'(1)));
    assign o_ready   = (CW'(DEPTH) - count_q >= CW'(NCMT)) && !trap_enq_q && !trap_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCMT; gi++) begin : g_lane
            assign wr_idx[gi]   = wr_ptr_q + AW'(gi);
            assign rd_idx[gi]   = rd_ptr_q + AW'(gi);
            assign in_trap[gi]  = i_inst[gi*32 +: 7] == TRAP_OP;
            assign ent_trap[gi] = mem_inst[rd_idx[gi]][6:0] == TRAP_OP;
            assign pc_d[gi*XLEN +: XLEN]    = valid_d[gi] ? mem_pc[rd_idx[gi]] : '0;
            assign inst_d[gi*32 +: 32]      = valid_d[gi] ? mem_inst[rd_idx[gi]] : '0;
            assign wdest_d[gi*8 +: 8]       = valid_d[gi] ? {3'b000, mem_rd[rd_idx[gi]]} : 8'h00;
            assign wen_d[gi]                = valid_d[gi] & mem_wen[rd_idx[gi]];
            assign wdata_d[gi*XLEN +: XLEN] = valid_d[gi] ? mem_wdata[rd_idx[gi]] : '0;
            assign skip_d[gi]               = valid_d[gi] & mem_skip[rd_idx[gi]];
        end
    endgenerate

    // Enqueue the contiguous valid prefix, stopping after a trap lane.
    always_comb begin
        take     = '0;
        n_enq    = '0;
        grp_trap = 1'b0;
        enq_stop = ~o_ready;
        for (int k = 0; k < NCMT; k++) begin
            if (!enq_stop && i_valid[k]) begin
                take[k] = 1'b1;
                n_enq   = n_enq + CW'(1);
                if (in_trap[k]) begin
                    grp_trap = 1'b1;
                    enq_stop = 1'b1;
                end
            end else begin
                enq_stop = 1'b1;
            end
        end
    end

    // Dequeue up to NCMT entries present before the edge; a trap entry ends the group.
    always_comb begin
        valid_d     = '0;
        n_deq       = '0;
        deq_trap    = 1'b0;
        deq_code    = 8'h00;
        deq_pc      = '0;
        deq_last_pc = last_pc_q;
        deq_stop    = i_out_stall | trap_q;
        for (int k = 0; k < NCMT; k++) begin
            if (!deq_stop && CW'(k) < count_q) begin
                valid_d[k]  = 1'b1;
                n_deq       = n_deq + CW'(1);
                deq_last_pc = mem_pc[rd_idx[k]];
                if (ent_trap[k]) begin
                    deq_trap = 1'b1;
                    deq_code = mem_code[rd_idx[k]];
                    deq_pc   = mem_pc[rd_idx[k]];
                    deq_stop = 1'b1;
                end
            end else begin
                deq_stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCMT; k++) begin
            if (take[k]) begin
                mem_pc[wr_idx[k]]    <= i_pc[k*XLEN +: XLEN];
                mem_inst[wr_idx[k]]  <= i_inst[k*32 +: 32];
                mem_rd[wr_idx[k]]    <= i_rd[k*5 +: 5];
                mem_wen[wr_idx[k]]   <= i_rd_wen[k];
                mem_wdata[wr_idx[k]] <= i_rd_wdata[k*XLEN +: XLEN];
                mem_skip[wr_idx[k]]  <= i_skip[k];
                mem_code[wr_idx[k]]  <= i_a0[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            trap_enq_q  <= 1'b0;
            trap_q      <= 1'b0;
            overflow_q  <= 1'b0;
            order_q     <= 1'b0;
            trap_code_q <= 8'h00;
            trap_pc_q   <= '0;
            last_pc_q   <= '0;
            cycle_q     <= '0;
            instr_q     <= '0;
            wdog_q      <= '0;
            valid_q     <= '0;
            pc_q        <= '0;
            inst_q      <= '0;
            wdest_q     <= '0;
            wen_q       <= '0;
            wdata_q     <= '0;
            skip_q      <= '0;
        end else if (!trap_q) begin
            cycle_q    <= cycle_q + 64'd1;
            overflow_q <= overflow_q | ((|i_valid) & ~o_ready);
            order_q    <= order_q | gap;
            trap_enq_q <= trap_enq_q | grp_trap;
            wr_ptr_q   <= wr_ptr_q + n_enq[AW-1:0];
            rd_ptr_q   <= rd_ptr_q + n_deq[AW-1:0];
            count_q    <= deq_trap ? '0 : count_q + n_enq - n_deq;
            last_pc_q  <= deq_last_pc;
            if (!i_out_stall) begin
                valid_q <= valid_d;
                pc_q    <= pc_d;
                inst_q  <= inst_d;
                wdest_q <= wdest_d;
                wen_q   <= wen_d;
                wdata_q <= wdata_d;
                skip_q  <= skip_d;
                instr_q <= instr_q + 64'(n_deq);
            end
            if (deq_trap) begin
                trap_q      <= 1'b1;
                trap_code_q <= deq_code;
                trap_pc_q   <= deq_pc;
            end
            if (n_deq != '0) begin
                wdog_q <= '0;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                wdog_q      <= WW'(TIMEOUT);
                trap_q      <= 1'b1;
                trap_code_q <= 8'hFF;
                trap_pc_q   <= last_pc_q;
            end else begin
                wdog_q <= wdog_q + WW'(1);
            end
        end
    end

    assign o_cmt_valid = valid_q;
    assign o_cmt_pc    = pc_q;
    assign o_cmt_inst  = inst_q;
    assign o_cmt_wdest = wdest_q;
    assign o_cmt_wen   = wen_q;
    assign o_cmt_wdata = wdata_q;
    assign o_cmt_skip  = skip_q;
    assign o_trap      = trap_q;
    assign o_trap_code = trap_code_q;
    assign o_trap_pc   = trap_pc_q;
    assign o_cycle_cnt = cycle_q;
    assign o_instr_cnt = instr_q;
    assign o_overflow  = overflow_q;
    assign o_order_err = order_q;
endmodule

// File: tb/tb_cmt_queue.sv
`timescale 1ns/1ps
// Bench for cmt_queue: directed scenarios plus random traffic, all checked cycle by cycle
// against a queue-based model of the commit rules.
module tb_cmt_queue;
    localparam int NCMT = 2, DEPTH = 8, XLEN = 64, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCMT-1:0]      i_valid, i_rd_wen, i_skip;
    logic [NCMT*XLEN-1:0] i_pc, i_rd_wdata;
    logic [NCMT*32-1:0]   i_inst;
    logic [NCMT*5-1:0]    i_rd;
    logic [XLEN-1:0]      i_a0;
    logic                 i_out_stall;
    logic                 o_ready, o_trap, o_overflow, o_order_err;
    logic [NCMT-1:0]      o_cmt_valid, o_cmt_wen, o_cmt_skip;
    logic [NCMT*XLEN-1:0] o_cmt_pc, o_cmt_wdata;
    logic [NCMT*32-1:0]   o_cmt_inst;
    logic [NCMT*8-1:0]    o_cmt_wdest;
    logic [7:0]           o_trap_code;
    logic [XLEN-1:0]      o_trap_pc;
    logic [63:0]          o_cycle_cnt, o_instr_cnt;

    cmt_queue #(.NCMT(NCMT), .DEPTH(DEPTH), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_inst(i_inst), .i_rd(i_rd),
        .i_rd_wen(i_rd_wen), .i_rd_wdata(i_rd_wdata), .i_skip(i_skip), .i_a0(i_a0),
        .i_out_stall(i_out_stall), .o_ready(o_ready), .o_cmt_valid(o_cmt_valid),
        .o_cmt_pc(o_cmt_pc), .o_cmt_inst(o_cmt_inst), .o_cmt_wdest(o_cmt_wdest),
        .o_cmt_wen(o_cmt_wen), .o_cmt_wdata(o_cmt_wdata), .o_cmt_skip(o_cmt_skip),
        .o_trap(o_trap), .o_trap_code(o_trap_code), .o_trap_pc(o_trap_pc),
        .o_cycle_cnt(o_cycle_cnt), .o_instr_cnt(o_instr_cnt), .o_overflow(o_overflow),
        .o_order_err(o_order_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        logic        skip;
        logic [7:0]  code;
    } ent_t;

    ent_t        q[$];
    ent_t        m_out [NCMT];
    logic [NCMT-1:0] m_vld;
    bit          m_trap, m_tenq, m_ovf, m_ord;
    logic [7:0]  m_code;
    logic [63:0] m_tpc, m_cyc, m_icnt, m_last;
    int          m_wd;
    int          n_chk = 0, n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (DEPTH - q.size() >= NCMT) && !m_tenq && !m_trap;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < NCMT; k++) m_out[k] = '{default: '0};
        m_vld = '0; m_trap = 0; m_tenq = 0; m_ovf = 0; m_ord = 0;
        m_code = '0; m_tpc = '0; m_cyc = '0; m_icnt = '0; m_last = '0; m_wd = 0;
    endtask

    task automatic clear_inputs();
        i_valid = '0; i_pc = '0; i_inst = '0; i_rd = '0; i_rd_wen = '0;
        i_rd_wdata = '0; i_skip = '0; i_a0 = '0; i_out_stall = 1'b0;
    endtask

    task automatic set_lane(input int k, input logic [63:0] pc, input logic [31:0] inst);
        logic [31:0] r;
        r = $urandom();
        i_valid[k] = 1'b1;
        i_pc[k*XLEN +: XLEN] = pc;
        i_inst[k*32 +: 32] = inst;
        i_rd[k*5 +: 5] = r[4:0];
        i_rd_wen[k] = r[5];
        i_skip[k] = r[6];
        i_rd_wdata[k*XLEN +: XLEN] = {$urandom(), $urandom()};
    endtask

    task automatic check_outputs();
        check_val("trap", o_trap, m_trap);
        check_val("trap_code", o_trap_code, m_code);
        check_val("trap_pc", o_trap_pc, m_tpc);
        check_val("cycle_cnt", o_cycle_cnt, m_cyc);
        check_val("instr_cnt", o_instr_cnt, m_icnt);
        check_val("overflow", o_overflow, m_ovf);
        check_val("order_err", o_order_err, m_ord);
        check_val("cmt_valid", o_cmt_valid, m_vld);
        for (int k = 0; k < NCMT; k++) begin
            if (m_vld[k]) begin
                check_val($sformatf("pc%0d", k), o_cmt_pc[k*XLEN +: XLEN], m_out[k].pc);
                check_val($sformatf("inst%0d", k), o_cmt_inst[k*32 +: 32], m_out[k].inst);
                check_val($sformatf("wdest%0d", k), o_cmt_wdest[k*8 +: 8], {3'b000, m_out[k].rd});
                check_val($sformatf("wen%0d", k), o_cmt_wen[k], m_out[k].wen);
                check_val($sformatf("wdata%0d", k), o_cmt_wdata[k*XLEN +: XLEN], m_out[k].wdata);
                check_val($sformatf("skip%0d", k), o_cmt_skip[k], m_out[k].skip);
            end
        end
    endtask

    // Advance the model over one edge using the current inputs, clock the DUT, compare.
    task automatic step();
        bit rdy, deq, hit, stop;
        int cnt;
        ent_t e;
        rdy = m_ready();
        check_val("ready", o_ready, rdy);
        if (!m_trap) begin
            m_cyc++;
            if (i_valid != 0 && !rdy) m_ovf = 1;
            for (int k = 1; k < NCMT; k++)
                for (int j = 0; j < k; j++)
                    if (i_valid[k] && !i_valid[j]) m_ord = 1;
            deq = 0; hit = 0;
            if (!i_out_stall) begin
                cnt = (q.size() < NCMT) ? q.size() : NCMT;
                m_vld = '0;
                for (int k = 0; k < cnt && !hit; k++) begin
                    e = q.pop_front();
                    m_out[k] = e; m_vld[k] = 1'b1; m_icnt++; m_last = e.pc; deq = 1;
                    if (e.inst[6:0] == 7'h6b) begin
                        hit = 1; m_trap = 1; m_code = e.code; m_tpc = e.pc; q.delete();
                    end
                end
            end
            if (!hit && rdy) begin
                stop = 0;
                for (int k = 0; k < NCMT; k++) begin
                    if (!stop && i_valid[k]) begin
                        e.pc = i_pc[k*XLEN +: XLEN]; e.inst = i_inst[k*32 +: 32];
                        e.rd = i_rd[k*5 +: 5]; e.wen = i_rd_wen[k];
                        e.wdata = i_rd_wdata[k*XLEN +: XLEN]; e.skip = i_skip[k];
                        e.code = i_a0[7:0];
                        q.push_back(e);
                        if (e.inst[6:0] == 7'h6b) begin m_tenq = 1; stop = 1; end
                    end else stop = 1;
                end
            end
            if (deq) m_wd = 0;
            else if (m_wd == TIMEOUT - 1) begin
                m_trap = 1; m_code = 8'hFF; m_tpc = m_last; m_wd = TIMEOUT;
            end else m_wd++;
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    // Asynchronous reset applied between clock edges, checked before any edge arrives.
    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        model_reset();
        check_outputs();
        check_val("rst_ready", o_ready, 1);
        check_val("rst_lanes", {63'b0, |{o_cmt_pc, o_cmt_inst, o_cmt_wdest, o_cmt_wen,
                                        o_cmt_wdata, o_cmt_skip}}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int sent;
        logic [31:0] r;
        clear_inputs();
        #2;

        // Two-lane group appears one edge after enqueue.
        apply_reset();
        set_lane(0, 64'h8000_0000, 32'h0000_0013);
        set_lane(1, 64'h8000_0004, 32'h0000_0013);
        step();
        clear_inputs();
        step();
        check_val("t1_valid", o_cmt_valid, 2'b11);
        check_val("t1_pc0", o_cmt_pc[63:0], 64'h8000_0000);
        check_val("t1_pc1", o_cmt_pc[127:64], 64'h8000_0004);
        check_val("t1_icnt", o_instr_cnt, 2);

        // Fill under stall, overflow a group, then drain in order.
        apply_reset();
        i_out_stall = 1'b1;
        for (int g = 0; g < 5; g++) begin
            set_lane(0, 64'h1000 + 64'(16 * g), 32'h13);
            set_lane(1, 64'h1008 + 64'(16 * g), 32'h13);
            step();
        end
        check_val("t2_ready_full", o_ready, 0);
        check_val("t2_overflow", o_overflow, 1);
        clear_inputs();
        for (int c = 0; c < 5; c++) step();
        check_val("t2_icnt", o_instr_cnt, 8);

        // Trap entry in lane 0 suppresses lane 1 and freezes the unit.
        apply_reset();
        set_lane(0, 64'h100, 32'h0000_006b);
        set_lane(1, 64'h104, 32'h13);
        i_a0 = 64'h7;
        step();
        clear_inputs();
        step();
        check_val("t3_trap", o_trap, 1);
        check_val("t3_code", o_trap_code, 8'h07);
        check_val("t3_tpc", o_trap_pc, 64'h100);
        check_val("t3_valid", o_cmt_valid, 2'b01);
        for (int c = 0; c < 3; c++) step();
        check_val("t3_cyc_frozen", o_cycle_cnt, 2);

        // Lane 1 valid without lane 0: ordering error, nothing enqueued.
        apply_reset();
        set_lane(1, 64'h300, 32'h13);
        i_valid = 2'b10;
        step();
        clear_inputs();
        step();
        check_val("t4_order", o_order_err, 1);
        check_val("t4_valid", o_cmt_valid, 0);
        check_val("t4_icnt", o_instr_cnt, 0);

        // Watchdog fires exactly TIMEOUT edges after the last commit.
        apply_reset();
        set_lane(0, 64'h200, 32'h13);
        step();
        clear_inputs();
        step();
        for (int c = 0; c < TIMEOUT - 1; c++) step();
        check_val("t5_no_trap_yet", o_trap, 0);
        step();
        check_val("t5_trap", o_trap, 1);
        check_val("t5_code", o_trap_code, 8'hFF);
        check_val("t5_tpc", o_trap_pc, 64'h200);

        // Twenty single-lane groups across pointer wrap with random stall.
        apply_reset();
        sent = 0;
        for (int c = 0; c < 200 && (sent < 20 || q.size() != 0 || o_cmt_valid != 0); c++) begin
            clear_inputs();
            i_out_stall = (sent < 20) && ($urandom_range(0, 2) == 0);
            if (sent < 20 && m_ready()) begin
                set_lane(0, 64'h4000 + 64'(4 * sent), 32'h13);
                sent++;
            end
            step();
        end
        check_val("t6_sent", sent, 20);
        check_val("t6_icnt", o_instr_cnt, 20);
        check_val("t6_trap", o_trap, 0);

        // Random traffic, including gaps, traps, overflow and mid-run resets.
        for (int run = 0; run < 4; run++) begin
            apply_reset();
            for (int c = 0; c < 60; c++) begin
                clear_inputs();
                for (int k = 0; k < NCMT; k++) begin
                    r = $urandom();
                    if ($urandom_range(0, 3) != 0)
                        set_lane(k, {32'h0, $urandom()},
                                 ($urandom_range(0, 24) == 0) ? {r[31:7], 7'h6b} : r);
                end
                i_a0 = {$urandom(), $urandom()};
                i_out_stall = ($urandom_range(0, 3) == 0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
